// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared types and segment patterns for the BCD display mux
package bcd_display_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] bcd_t;

    // Active-low, bit order {g,f,e,d,c,b,a}
    localparam seg7_t SEG_0    = 7'b1000000;
    localparam seg7_t SEG_1    = 7'b1111001;
    localparam seg7_t SEG_2    = 7'b0100100;
    localparam seg7_t SEG_3    = 7'b0110000;
    localparam seg7_t SEG_4    = 7'b0011001;
    localparam seg7_t SEG_5    = 7'b0010010;
    localparam seg7_t SEG_6    = 7'b0000010;
    localparam seg7_t SEG_7    = 7'b1111000;
    localparam seg7_t SEG_8    = 7'b0000000;
    localparam seg7_t SEG_9    = 7'b0010000;
    localparam seg7_t SEG_DASH = 7'b0111111;
    localparam seg7_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to active-low 7-segment decoder, dash for 10..15
module bcd_to_seg7
    import bcd_display_pkg::*;
(
    input  bcd_t  bcd,
    output seg7_t seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - frame-snapshotted multiplexed 7-segment driver; BCD_DISPLAY_LEADING_ZERO_BLANK_EN adds leading-zero blanking
module bcd_display_mux
    import bcd_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 0
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    ENABLE,
    input  logic [4*NUM_DIGITS-1:0] DIGITS,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    output logic [NUM_DIGITS-1:0]   AN,
    output seg7_t                   SEG,
    output logic                    DP,
    output logic                    FRAME_TICK
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;

    logic                    cnt_last;
    logic                    idx_last;
    logic                    frame_wrap;
    logic                    in_blank;
    logic                    cur_blank;
    logic                    cur_dp;
    bcd_t                    cur_digit;
    seg7_t                   seg_dec;
    logic [NUM_DIGITS-1:0]   an_lit;

    assign cnt_last   = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign idx_last   = (idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_wrap = cnt_last && idx_last;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // Compare-based select keeps non-power-of-two digit counts in range
    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_lit[k] = (idx != IDX_W'(k));
            if (idx == IDX_W'(k)) begin
                cur_digit = snap_digits[4*k +: 4];
                cur_dp    = snap_dp[k];
            end
        end
    end

`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] snap_zero_blank;
    logic [NUM_DIGITS-1:0] next_zero_blank;
    logic                  seen_sig;

    // Blank from the top down until a nonzero digit or a lit point appears
    always_comb begin
        next_zero_blank = '0;
        seen_sig        = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (!seen_sig && (DIGITS[4*k +: 4] == 4'd0) && !DP_IN[k]) begin
                next_zero_blank[k] = 1'b1;
            end else begin
                seen_sig = 1'b1;
            end
        end
    end

    always_comb begin
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_blank = snap_zero_blank[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            snap_zero_blank <= '0;
        end else if (ENABLE && frame_wrap) begin
            snap_zero_blank <= next_zero_blank;
        end
    end
`else
    assign cur_blank = 1'b0;
`endif

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (seg_dec)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            AN          <= '1;
            SEG         <= SEG_OFF;
            DP          <= 1'b1;
            FRAME_TICK  <= 1'b0;
        end else if (!ENABLE) begin
            AN         <= '1;
            SEG        <= SEG_OFF;
            DP         <= 1'b1;
            FRAME_TICK <= 1'b0;
        end else begin
            FRAME_TICK <= frame_wrap;
            if (cnt_last) begin
                cnt <= '0;
                idx <= idx_last ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (frame_wrap) begin
                snap_digits <= DIGITS;
                snap_dp     <= DP_IN;
            end
            if (in_blank || cur_blank) begin
                AN  <= '1;
                SEG <= SEG_OFF;
                DP  <= 1'b1;
            end else begin
                AN  <= an_lit;
                SEG <= seg_dec;
                DP  <= ~cur_dp;
            end
        end
    end

endmodule
